// File: rtl/cmd_byte_dispatcher.sv
// cmd_byte_dispatcher
// Buffers one framed host packet (header [7:4]=target, [3:0]=length, then
// payload), pulses the target's mask bit for one cycle and streams the payload
// on cmd_data, one byte per acked cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_data/in_valid      host byte stream; in_ready = byte accepted on edge
//   mask                  registered one-cycle one-hot target select
//   cmd_data              shared payload bus (valid on every acked cycle)
//   data_ack              OR of unit acks; unit samples cmd_data this cycle
//   busy                  high whenever not idle
//   err                   sticky: [0] bad target [1] ack timeout
//                         [2] short ack [3] overrun / checksum mismatch
//   err_clr               synchronous clear of err (a same-edge set wins)
//
// Build option: define CMD_DISPATCH_CHECKSUM_EN to require a trailing checksum
// byte per packet (header + payload + checksum must sum to 0x00 mod 256).
module cmd_byte_dispatcher #(
    parameter int unsigned N_TARGETS = 8,
    parameter int unsigned MAX_LEN   = 15,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N_TARGETS-1:0] mask,
    output logic [7:0]           cmd_data,
    input  logic                 data_ack,
    output logic                 busy,
    output logic [3:0]           err,
    input  logic                 err_clr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [4:0]  NT = 5'(N_TARGETS);
    localparam logic [4:0]  ML = 5'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, SIGNAL, WAIT_ACK, STREAM} state_t;

    state_t         state_q, state_d;
    logic [3:0]     tgt_q, tgt_d;
    logic [3:0]     len_q, len_d;
    logic [3:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     err_set;
    logic           wr_en;
    logic           accept;
    logic [7:0]     pay_buf [MAX_LEN];
`ifdef CMD_DISPATCH_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        err_set = '0;
        wr_en   = 1'b0;
`ifdef CMD_DISPATCH_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d = in_data[7:4];
                    len_d = in_data[3:0];
                    idx_d = '0;
`ifdef CMD_DISPATCH_CHECKSUM_EN
                    // L=0 still has a checksum byte to consume
                    sum_d   = in_data;
                    state_d = LOAD;
`else
                    if (in_data[3:0] != 4'd0) state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
`ifdef CMD_DISPATCH_CHECKSUM_EN
                    sum_d = 8'(sum_q + in_data);
                    if (idx_q == len_q) begin
                        // trailing checksum byte: checked, never stored
                        idx_d = '0;
                        if (8'(sum_q + in_data) != 8'h00) begin
                            err_set[3] = 1'b1;
                            state_d    = IDLE;
                        end else if (len_q == 4'd0) begin
                            state_d = IDLE;
                        end else if ({1'b0, tgt_q} >= NT) begin
                            err_set[0] = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = SIGNAL;
                        end
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 4'd1;
                    end
`else
                    wr_en = 1'b1;
                    if (idx_q == len_q - 4'd1) begin
                        idx_d = '0;
                        if ({1'b0, tgt_q} >= NT) begin
                            err_set[0] = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = SIGNAL;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
`endif
                end
            end
            SIGNAL: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (data_ack) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = STREAM;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_set[1] = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STREAM: begin
                if (data_ack) begin
                    if (idx_q == len_q) err_set[3] = 1'b1;
                    else                idx_d      = idx_q + 4'd1;
                end else begin
                    if (idx_q != len_q) err_set[2] = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            mask     <= '0;
            in_ready <= 1'b0;
            err      <= '0;
`ifdef CMD_DISPATCH_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            // mask is high exactly for the single SIGNAL cycle
            mask     <= (state_d == SIGNAL) ? (N_TARGETS'(1) << tgt_d) : '0;
            // registered so it reads 0 in reset yet tracks IDLE/LOAD afterwards
            in_ready <= (state_d == IDLE) || (state_d == LOAD);
            err      <= (err_clr ? 4'd0 : err) | err_set;
`ifdef CMD_DISPATCH_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, idx_q} < ML)) pay_buf[idx_q] <= in_data;
    end

    always_comb begin
        cmd_data = '0;
        if (state_q == WAIT_ACK)
            cmd_data = pay_buf[0];
        else if (state_q == STREAM && idx_q < len_q && {1'b0, idx_q} < ML)
            cmd_data = pay_buf[idx_q];
    end

endmodule

// File: tb/tb_cmd_byte_dispatcher.sv
// Testbench for cmd_byte_dispatcher: directed packets plus randomized packets,
// expected mask pulses and acked bytes are queued by a packet-level model and
// compared by an independent monitor.
module tb_cmd_byte_dispatcher;

    localparam int unsigned NT = 8;
    localparam int unsigned ML = 15;
    localparam int unsigned TO = 255;

    logic          clk = 1'b0;
    logic          reset, in_valid, data_ack, err_clr, in_ready, busy;
    logic [7:0]    in_data, cmd_data;
    logic [NT-1:0] mask;
    logic [3:0]    err;

    int unsigned   checks = 0;
    int unsigned   passes = 0;
    logic [NT-1:0] exp_mask_q [$];
    logic [7:0]    exp_byte_q [$];
    logic [7:0]    cap_q [$];
    logic [3:0]    model_err;

    always #5 clk = ~clk;

    cmd_byte_dispatcher #(.N_TARGETS(NT), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mask(mask), .cmd_data(cmd_data),
        .data_ack(data_ack), .busy(busy), .err(err), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: every mask pulse and every acked byte must match the model queue
    initial forever begin
        @(negedge clk);
        if (mask != '0) begin
            if (exp_mask_q.size() == 0) chk("unexpected_mask", 32'(mask), 32'd0);
            else                        chk("mask", 32'(mask), 32'(exp_mask_q.pop_front()));
        end
        if (data_ack) begin
            cap_q.push_back(cmd_data);
            if (exp_byte_q.size() == 0) chk("unexpected_ack", 32'(data_ack), 32'd0);
            else                        chk("cmd_data", 32'(cmd_data), 32'(exp_byte_q.pop_front()));
        end
    end

    // called #1 after a posedge; returns #1 after the accepting posedge
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit ok;
        int unsigned n;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 50);
        #1 in_valid = 1'b0;
        if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_packet(input logic [7:0] hdr, input logic [7:0] pl [$],
                              input int unsigned gap, input int unsigned dly,
                              input int unsigned acks, input bit reset_mid);
        int unsigned   tgt, len, n;
        logic [NT-1:0] em;
        logic [7:0]    bytes [$];
        bit            dispatched;
`ifdef CMD_DISPATCH_CHECKSUM_EN
        logic [7:0]    sum;
`endif
        tgt = 32'(hdr[7:4]);
        len = 32'(hdr[3:0]);
        em  = '0;
        bytes.push_back(hdr);
        foreach (pl[i]) bytes.push_back(pl[i]);
`ifdef CMD_DISPATCH_CHECKSUM_EN
        sum = '0;
        foreach (bytes[i]) sum = 8'(sum + bytes[i]);
        bytes.push_back(8'(8'd0 - sum));
`endif
        // packet-level model
        dispatched = (len != 0) && (tgt < NT);
        if (len != 0 && tgt >= NT) model_err[0] = 1'b1;
        if (dispatched) begin
            em = NT'(1) << tgt;
            exp_mask_q.push_back(em);
            if (acks == 0) model_err[1] = 1'b1;
            else begin
                for (int unsigned k = 0; k < acks; k++)
                    exp_byte_q.push_back(k < len ? pl[k] : 8'h00);
                if (!reset_mid) begin
                    if (acks < len) model_err[2] = 1'b1;
                    if (acks > len) model_err[3] = 1'b1;
                end
            end
        end

        foreach (bytes[i]) send_byte(bytes[i], gap);
        @(negedge clk);
        chk("mask_after_last_byte", 32'(mask), 32'(em));
        if (!dispatched) chk("busy_after_drop", 32'(busy), 32'd0);
        @(posedge clk); #1;

        if (dispatched) begin
            if (acks == 0) begin
                n = 0;
                do begin
                    @(negedge clk);
                    if (busy) n++;
                end while (busy && n < 1000);
                chk("timeout_cycles", n, TO);
                @(posedge clk); #1;
            end else begin
                repeat (dly - 1) begin @(posedge clk); #1; end
                data_ack = 1'b1;
                repeat (acks) begin @(posedge clk); #1; end
                data_ack = 1'b0;
                if (reset_mid) begin
                    reset = 1'b1;
                    #1;
                    model_err = '0;
                    chk("rst_mask", 32'(mask), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_err", 32'(err), 32'd0);
                    chk("rst_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk); #1 reset = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    n = 0;
                    while (busy && n < 20) begin @(posedge clk); #1; n++; end
                end
            end
        end
        chk("busy_end", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(model_err));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        model_err = '0;
        chk("err_clr", 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0]  empty_q [$];
        logic [7:0]  rq [$];
        logic [31:0] value;
        int unsigned tgt, len, acks;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; data_ack = 1'b0; err_clr = 1'b0;
        model_err = '0;
        #1;
        chk("reset_mask", 32'(mask), 32'd0);
        chk("reset_cmd_data", 32'(cmd_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // pulse-sequencer consumer: 4 value bytes + 1 setting byte
        cap_q.delete();
        run_packet(8'h25, '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01}, 0, 1, 5, 1'b0);
        chk("cap_count", cap_q.size(), 32'd5);
        if (cap_q.size() == 5) begin
            value = {cap_q[0], cap_q[1], cap_q[2], cap_q[3]};
            chk("seq_value", value, 32'h12345678);
            chk("seq_setting", 32'(cap_q[4][3:0]), 32'h1);
        end
        // same packet with 3-cycle gaps between bytes
        run_packet(8'h25, '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01}, 3, 2, 5, 1'b0);
        // bad target then a normal packet
        run_packet(8'h92, '{8'hC3, 8'h3C}, 0, 1, 2, 1'b0);
        run_packet(8'h11, '{8'hAA}, 1, 1, 1, 1'b0);
        // ack timeout
        run_packet(8'h31, '{8'h55}, 0, 1, 0, 1'b0);
        clear_err();
        // short ack, then overrun
        run_packet(8'h03, '{8'hAA, 8'hBB, 8'hCC}, 0, 1, 2, 1'b0);
        clear_err();
        run_packet(8'h03, '{8'hAA, 8'hBB, 8'hCC}, 0, 3, 5, 1'b0);
        // reset during stream after 2 acks, then L=0 header and a full packet
        run_packet(8'h53, '{8'h01, 8'h02, 8'h03}, 0, 1, 2, 1'b1);
        run_packet(8'h10, empty_q, 0, 1, 0, 1'b0);
        run_packet(8'h42, '{8'hDE, 8'hAD}, 0, 1, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            tgt = ($urandom % 4 == 0) ? 8 + $urandom % 8 : $urandom % 8;
            len = $urandom % 16;
            rq.delete();
            for (int unsigned k = 0; k < len; k++) rq.push_back(8'($urandom));
            acks = ($urandom % 10 == 0) ? 0 : 1 + $urandom % (len + 2);
            run_packet({4'(tgt), 4'(len)}, rq, $urandom % 3, 1 + $urandom % 4, acks, 1'b0);
            if (r % 8 == 7) clear_err();
        end

        chk("mask_queue_drained", exp_mask_q.size(), 32'd0);
        chk("byte_queue_drained", exp_byte_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
